float_normalize_round: RTL and testbench

- Downstream stage of the float adder/subtractor datapath.
- Consumes an unnormalized sign/exponent/extended-mantissa sum and produces a packed IEEE-754 single.
- Normalizes iteratively, one bit per cycle, then rounds to nearest-even and detects overflow/underflow.
- Uses valid/ready handshakes on both sides so the FPU controller can stall it.

---
 rtl/float_normalize_round.sv | 221 ++++++++++++++++++++++
 tb/tb_float_normalize_round.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/float_normalize_round.sv
// Normalize, round-to-nearest-even and pack stage of the float add/sub datapath.
// Optional gradual underflow (denormal results) enabled by `define FLOAT_NORMALIZE_DENORMAL_EN.
module float_normalize_round #(
  parameter int MAX_SHIFT = 26
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_special,
  input  logic [31:0] in_special_value,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_DONE
`ifdef FLOAT_NORMALIZE_DENORMAL_EN
    , S_DENORM
`endif
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [31:0]        out_result_q;
  logic               overflow_q;
  logic               underflow_q;
  logic               inexact_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [27:0]        mant_q;
  logic [CNT_W-1:0]   cnt_q;

  // Shared single-step datapath helpers.
  logic signed [9:0]  exp_inc_d;
  logic signed [9:0]  exp_dec_d;
  logic [27:0]        mant_shr_d;
  logic [27:0]        mant_shl_d;
  logic [CNT_W-1:0]   cnt_inc_d;

  // One NORM step.
  logic [27:0]        norm_mant_d;
  logic signed [9:0]  norm_exp_d;
  logic [CNT_W-1:0]   norm_cnt_d;
  logic               norm_done_d;
  state_t             norm_next_d;

  // Rounding and packing.
  logic               round_up;
  logic [24:0]        rnd_sum;
  logic               rnd_carry;
  logic [22:0]        rnd_frac;
  logic signed [10:0] exp_rnd;
  logic [31:0]        pack_result_d;
  logic               pack_ovf_d;
  logic               pack_unf_d;
  logic               pack_inx_d;
`ifdef FLOAT_NORMALIZE_DENORMAL_EN
  logic               rnd_hidden;
`endif

  // NOTE: every signal driven from always_comb gets a default at the top so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    // Exponent saturates at the 10-bit signed limits instead of wrapping.
    exp_inc_d  = (exp_q == 10'sd511)  ? exp_q : exp_q + 10'sd1;
    exp_dec_d  = (exp_q == 10'sh200) ? exp_q : exp_q - 10'sd1;
    mant_shr_d = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
    mant_shl_d = {mant_q[26:0], 1'b0};
    cnt_inc_d  = cnt_q + CNT_W'(1);

    norm_mant_d = mant_q;
    norm_exp_d  = exp_q;
    norm_cnt_d  = cnt_q;
    norm_done_d = 1'b0;
    if (mant_q[27]) begin
      norm_mant_d = mant_shr_d;
      norm_exp_d  = exp_inc_d;
      norm_done_d = 1'b1;
    end else if (mant_q[26]) begin
      norm_done_d = 1'b1;
    end else begin
      norm_mant_d = mant_shl_d;
      norm_exp_d  = exp_dec_d;
      norm_cnt_d  = cnt_inc_d;
      norm_done_d = (cnt_inc_d == CNT_W'(MAX_SHIFT));
    end

    norm_next_d = S_NORM;
    if (norm_done_d) begin
      norm_next_d = S_ROUND;
`ifdef FLOAT_NORMALIZE_DENORMAL_EN
      if (norm_exp_d <= 10'sd0) norm_next_d = S_DENORM;
`endif
    end
  end

  always_comb begin
    round_up  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rnd_sum   = mant_q[27:3] + {24'd0, round_up};
    rnd_carry = rnd_sum[24];
    rnd_frac  = rnd_carry ? rnd_sum[23:1] : rnd_sum[22:0];
    exp_rnd   = {exp_q[9], exp_q} + {10'd0, rnd_carry};
`ifdef FLOAT_NORMALIZE_DENORMAL_EN
    rnd_hidden = rnd_carry | rnd_sum[23];
`endif

    pack_inx_d    = |mant_q[2:0];
    pack_ovf_d    = 1'b0;
    pack_unf_d    = 1'b0;
    pack_result_d = {sign_q, exp_rnd[7:0], rnd_frac};
    if (exp_rnd >= 11'sd255) begin
      pack_result_d = {sign_q, 8'hFF, 23'd0};
      pack_ovf_d    = 1'b1;
    end else if (exp_rnd <= 11'sd0) begin
      pack_result_d = {sign_q, 31'd0};
      pack_unf_d    = 1'b1;
    end
`ifdef FLOAT_NORMALIZE_DENORMAL_EN
    else if (!rnd_hidden) begin
      // Exponent is 1 here; a missing hidden bit means a denormal encoding.
      pack_result_d = {sign_q, 8'h00, rnd_frac};
      pack_unf_d    = pack_inx_d;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      inexact_q    <= 1'b0;
      sign_q       <= 1'b0;
      exp_q        <= 10'sd0;
      mant_q       <= 28'd0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            sign_q     <= in_sign;
            exp_q      <= in_exp;
            mant_q     <= in_mant;
            cnt_q      <= '0;
            if (in_special || in_mant == 28'd0) begin
              out_result_q <= in_special ? in_special_value : {in_sign, 31'd0};
              overflow_q   <= 1'b0;
              underflow_q  <= 1'b0;
              inexact_q    <= 1'b0;
              out_valid_q  <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              state_q <= S_NORM;
            end
          end
        end
        S_NORM: begin
          mant_q  <= norm_mant_d;
          exp_q   <= norm_exp_d;
          cnt_q   <= norm_cnt_d;
          state_q <= norm_next_d;
        end
`ifdef FLOAT_NORMALIZE_DENORMAL_EN
        S_DENORM: begin
          mant_q <= mant_shr_d;
          exp_q  <= exp_inc_d;
          if (exp_inc_d == 10'sd1) state_q <= S_ROUND;
        end
`endif
        S_ROUND: begin
          out_result_q <= pack_result_d;
          overflow_q   <= pack_ovf_d;
          underflow_q  <= pack_unf_d;
          inexact_q    <= pack_inx_d;
          out_valid_q  <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_overflow  = overflow_q;
  assign out_underflow = underflow_q;
  assign out_inexact   = inexact_q;

endmodule

// File: tb/tb_float_normalize_round.sv
// Directed, table-driven bench for float_normalize_round plus hand-written
// handshake-stall and mid-operation reset sequences.
module tb_float_normalize_round;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic        in_special;
  logic [31:0] in_special_value;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int checks   = 0;
  int failures = 0;

  float_normalize_round dut (
    .clk              (clk),
    .clr              (clr),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_special       (in_special),
    .in_special_value (in_special_value),
    .in_sign          (in_sign),
    .in_exp           (in_exp),
    .in_mant          (in_mant),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_overflow     (out_overflow),
    .out_underflow    (out_underflow),
    .out_inexact      (out_inexact)
  );

  always #5 clk = ~clk;

  // lat = clock edges after the acceptance edge until out_valid is seen;
  // special/zero results are already valid right after the acceptance edge.
  typedef struct {
    string       name;
    logic        special;
    logic [31:0] sval;
    logic        sign;
    logic [9:0]  exp;
    logic [27:0] mant;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    int          lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({v.name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_special       = v.special;
    in_special_value = v.sval;
    in_sign          = v.sign;
    in_exp           = v.exp;
    in_mant          = v.mant;
    in_valid         = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check({v.name, ".latency"}, n, v.lat);
    check({v.name, ".result"}, out_result, v.res);
    check({v.name, ".overflow"}, {31'd0, out_overflow}, {31'd0, v.ovf});
    check({v.name, ".underflow"}, {31'd0, out_underflow}, {31'd0, v.unf});
    check({v.name, ".inexact"}, {31'd0, out_inexact}, {31'd0, v.inx});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;

    vecs[0]  = '{"carry_out",   1'b0, 32'h0, 1'b0, 10'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{"cancel",      1'b0, 32'h0, 1'b0, 10'd130, 28'h0000008, 32'h35800000, 1'b0, 1'b0, 1'b0, 25};
    vecs[2]  = '{"tie_even_dn", 1'b0, 32'h0, 1'b0, 10'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 1'b1, 2};
    vecs[3]  = '{"tie_even_up", 1'b0, 32'h0, 1'b0, 10'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 1'b1, 2};
    vecs[4]  = '{"rnd_carry",   1'b0, 32'h0, 1'b0, 10'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b0, 1'b1, 2};
    vecs[5]  = '{"rnd_ovf",     1'b0, 32'h0, 1'b0, 10'd254, 28'h7FFFFFC, 32'h7F800000, 1'b1, 1'b0, 1'b1, 2};
`ifdef FLOAT_NORMALIZE_DENORMAL_EN
    vecs[6]  = '{"underflow",   1'b0, 32'h0, 1'b1, 10'd1,   28'h2000000, 32'h80400000, 1'b0, 1'b0, 1'b0, 4};
    vecs[13] = '{"neg_exp",     1'b0, 32'h0, 1'b0, 10'h3FB, 28'h4000000, 32'h00020000, 1'b0, 1'b0, 1'b0, 8};
`else
    vecs[6]  = '{"underflow",   1'b0, 32'h0, 1'b1, 10'd1,   28'h2000000, 32'h80000000, 1'b0, 1'b1, 1'b0, 3};
    vecs[13] = '{"neg_exp",     1'b0, 32'h0, 1'b0, 10'h3FB, 28'h4000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 2};
`endif
    vecs[7]  = '{"special_nan", 1'b1, 32'h7FC00000, 1'b0, 10'd0, 28'h1234567, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 0};
    vecs[8]  = '{"neg_zero",    1'b0, 32'h0, 1'b1, 10'd50,  28'h0000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 0};
    vecs[9]  = '{"sticky_up",   1'b0, 32'h0, 1'b0, 10'd127, 28'h4000005, 32'h3F800001, 1'b0, 1'b0, 1'b1, 2};
    vecs[10] = '{"round_only",  1'b0, 32'h0, 1'b0, 10'd127, 28'h4000002, 32'h3F800000, 1'b0, 1'b0, 1'b1, 2};
    vecs[11] = '{"shr_norm",    1'b0, 32'h0, 1'b0, 10'd127, 28'hC000004, 32'h40400000, 1'b0, 1'b0, 1'b1, 2};
    vecs[12] = '{"big_exp",     1'b0, 32'h0, 1'b0, 10'd300, 28'h4000000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 2};

    clr              = 1'b1;
    in_valid         = 1'b0;
    in_special       = 1'b0;
    in_special_value = 32'd0;
    in_sign          = 1'b0;
    in_exp           = 10'd0;
    in_mant          = 28'd0;
    out_ready        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;

    check("reset.in_ready", {31'd0, in_ready}, 32'd1);
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("reset.out_result", out_result, 32'd0);
    check("reset.flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);

    for (int i = 0; i < NV; i++) apply(vecs[i]);

    // Output stall: result and flags must hold while out_ready stays low.
    in_special       = 1'b1;
    in_special_value = 32'h7FC00000;
    in_valid         = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_special = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d.out_valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("stall%0d.out_result", c), out_result, 32'h7FC00000);
      check($sformatf("stall%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_release.out_valid", {31'd0, out_valid}, 32'd0);
    check("stall_release.in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a long normalization discards the operation.
    in_exp   = 10'd130;
    in_mant  = 28'h0000008;
    in_sign  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_norm.busy", {31'd0, in_ready}, 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("mid_clr.out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_clr.in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_clr.out_result", out_result, 32'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mid_clr.discarded", seen, 0);
    apply(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
